// File: rtl/mem_pkg.sv
// Shared types and sizing helpers for the memory responder and its per-channel FSMs.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ_BUSY,
        WRITE_BUSY,
        RESPOND,
        DRAIN
    } chan_state_e;

    function automatic int max_latency(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of a down-counter that must hold values 0..max_lat.
    function automatic int latency_count_bits(input int max_lat);
        return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/mem_responder_channel.sv
// One request channel: accepts a read or write, counts out the latency, pulses ready,
// and tells the top when to sample or commit the array.
module mem_responder_channel
    import mem_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_valid,
    input  logic [ADDR_BITS-1:0] read_address,
    input  logic                 write_valid,
    input  logic [ADDR_BITS-1:0] write_address,
    input  logic [DATA_BITS-1:0] write_data,
    output logic                 read_ready,
    output logic                 write_ready,
    output logic                 read_commit,
    output logic                 write_commit,
    output logic [ADDR_BITS-1:0] commit_address,
    output logic [DATA_BITS-1:0] commit_data
);

    localparam int CW = latency_count_bits(max_latency(READ_LATENCY, WRITE_LATENCY));

    chan_state_e          state, state_next;
    logic [CW-1:0]        count, count_next;
    logic                 serving_read, serving_read_next;
    logic [ADDR_BITS-1:0] addr_q, addr_next;
    logic [DATA_BITS-1:0] data_q, data_next;
    logic                 read_ready_next, write_ready_next;
    logic                 served_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            serving_read <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            read_ready   <= 1'b0;
            write_ready  <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            serving_read <= serving_read_next;
            addr_q       <= addr_next;
            data_q       <= data_next;
            read_ready   <= read_ready_next;
            write_ready  <= write_ready_next;
        end
    end

    // Reads win over a simultaneous write; the write simply stays pending in IDLE.
    always_comb begin
        state_next        = state;
        count_next        = count;
        serving_read_next = serving_read;
        addr_next         = addr_q;
        data_next         = data_q;
        read_ready_next   = 1'b0;
        write_ready_next  = 1'b0;
        read_commit       = 1'b0;
        write_commit      = 1'b0;
        served_valid      = serving_read ? read_valid : write_valid;

        case (state)
            IDLE: begin
                if (read_valid) begin
                    state_next        = READ_BUSY;
                    count_next        = CW'(READ_LATENCY - 1);
                    serving_read_next = 1'b1;
                    addr_next         = read_address;
                end else if (write_valid) begin
                    state_next        = WRITE_BUSY;
                    count_next        = CW'(WRITE_LATENCY - 1);
                    serving_read_next = 1'b0;
                    addr_next         = write_address;
                    data_next         = write_data;
                end
            end
            READ_BUSY: begin
                if (count == '0) begin
                    state_next      = RESPOND;
                    read_ready_next = 1'b1;
                    read_commit     = 1'b1;
                end else begin
                    count_next = count - CW'(1);
                end
            end
            WRITE_BUSY: begin
                if (count == '0) begin
                    state_next       = RESPOND;
                    write_ready_next = 1'b1;
                    write_commit     = 1'b1;
                end else begin
                    count_next = count - CW'(1);
                end
            end
            RESPOND: begin
                state_next = served_valid ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (!served_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign commit_address = addr_q;
    assign commit_data    = data_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: a shared word array served by NUM_CHANNELS independent
// request FSMs, plus a backdoor preload port.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CHANNELS  = 1,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]           mem_read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
    input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
    output logic [NUM_CHANNELS-1:0]           mem_write_ready,
    input  logic                              init_we,
    input  logic [ADDR_BITS-1:0]              init_addr,
    input  logic [DATA_BITS-1:0]              init_data
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_BITS-1:0] mem_array [0:DEPTH-1];

    logic [NUM_CHANNELS-1:0] read_commit;
    logic [NUM_CHANNELS-1:0] write_commit;
    logic [ADDR_BITS-1:0]    commit_address [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    commit_data    [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    read_data_q    [NUM_CHANNELS];

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_channel
        mem_responder_channel #(
            .ADDR_BITS    (ADDR_BITS),
            .DATA_BITS    (DATA_BITS),
            .READ_LATENCY (READ_LATENCY),
            .WRITE_LATENCY(WRITE_LATENCY)
        ) u_channel (
            .clk           (clk),
            .reset         (reset),
            .read_valid    (mem_read_valid[g]),
            .read_address  (mem_read_address[g*ADDR_BITS +: ADDR_BITS]),
            .write_valid   (mem_write_valid[g]),
            .write_address (mem_write_address[g*ADDR_BITS +: ADDR_BITS]),
            .write_data    (mem_write_data[g*DATA_BITS +: DATA_BITS]),
            .read_ready    (mem_read_ready[g]),
            .write_ready   (mem_write_ready[g]),
            .read_commit   (read_commit[g]),
            .write_commit  (write_commit[g]),
            .commit_address(commit_address[g]),
            .commit_data   (commit_data[g])
        );

        // Sampling on the commit edge sees the pre-write word, giving read-before-write.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                read_data_q[g] <= '0;
            end else if (read_commit[g]) begin
                read_data_q[g] <= mem_array[commit_address[g]];
            end
        end

        assign mem_read_data[g*DATA_BITS +: DATA_BITS] = read_data_q[g];
    end

    // Later assignments override earlier ones: init loses to any channel, and the
    // highest channel index wins a same-address collision.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_array[init_addr] <= init_data;
        end
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (write_commit[c]) begin
                mem_array[commit_address[c]] <= commit_data[c];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomised scoreboard bench for mem_responder with two channels.
module tb_mem_responder;

    localparam int ADDR_BITS = 8;
    localparam int DATA_BITS = 16;
    localparam int NCH       = 2;
    localparam int RL        = 2;
    localparam int WL        = 1;

    logic                     clk       = 1'b0;
    logic                     reset     = 1'b0;
    logic [NCH-1:0]           rd_valid  = '0;
    logic [NCH*ADDR_BITS-1:0] rd_addr   = '0;
    logic [NCH-1:0]           rd_ready;
    logic [NCH*DATA_BITS-1:0] rd_data;
    logic [NCH-1:0]           wr_valid  = '0;
    logic [NCH*ADDR_BITS-1:0] wr_addr   = '0;
    logic [NCH*DATA_BITS-1:0] wr_data   = '0;
    logic [NCH-1:0]           wr_ready;
    logic                     init_we   = 1'b0;
    logic [ADDR_BITS-1:0]     init_addr = '0;
    logic [DATA_BITS-1:0]     init_data = '0;

    typedef struct {
        logic [DATA_BITS-1:0] data;
        int                   due;
    } exp_t;

    exp_t rd_q0[$];
    exp_t rd_q1[$];
    int   wr_q0[$];
    int   wr_q1[$];

    logic [DATA_BITS-1:0] model [0:255];
    int cycle    = 0;
    int checks   = 0;
    int failures = 0;

    mem_responder #(
        .ADDR_BITS    (ADDR_BITS),
        .DATA_BITS    (DATA_BITS),
        .NUM_CHANNELS (NCH),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_read_valid   (rd_valid),
        .mem_read_address (rd_addr),
        .mem_read_ready   (rd_ready),
        .mem_read_data    (rd_data),
        .mem_write_valid  (wr_valid),
        .mem_write_address(wr_addr),
        .mem_write_data   (wr_data),
        .mem_write_ready  (wr_ready),
        .init_we          (init_we),
        .init_addr        (init_addr),
        .init_data        (init_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // A request issued after edge N is sampled at N+1 and completes at edge N+1+latency.
    task automatic push_read(input int ch, input logic [ADDR_BITS-1:0] addr);
        exp_t e;
        e.data = model[addr];
        e.due  = cycle + 1 + RL;
        if (ch == 0) rd_q0.push_back(e);
        else         rd_q1.push_back(e);
    endtask

    task automatic push_write(input int ch, input int due);
        if (ch == 0) wr_q0.push_back(due);
        else         wr_q1.push_back(due);
    endtask

    task automatic mon_read(input int c);
        exp_t e;
        logic [DATA_BITS-1:0] got;
        got = rd_data[c*DATA_BITS +: DATA_BITS];
        checks++;
        if ((c == 0 && rd_q0.size() == 0) || (c == 1 && rd_q1.size() == 0)) begin
            failures++;
            $display("[TB] FAIL rd_ch%0d_unexpected: ready pulse at cycle %0d with no read pending", c, cycle);
        end else begin
            if (c == 0) e = rd_q0.pop_front();
            else        e = rd_q1.pop_front();
            if (got !== e.data || cycle != e.due) begin
                failures++;
                $display("[TB] FAIL rd_ch%0d: data 0x%0h at cycle %0d, expected 0x%0h at cycle %0d",
                         c, got, cycle, e.data, e.due);
            end
        end
    endtask

    task automatic mon_write(input int c);
        int due;
        checks++;
        if ((c == 0 && wr_q0.size() == 0) || (c == 1 && wr_q1.size() == 0)) begin
            failures++;
            $display("[TB] FAIL wr_ch%0d_unexpected: ready pulse at cycle %0d with no write pending", c, cycle);
        end else begin
            if (c == 0) due = wr_q0.pop_front();
            else        due = wr_q1.pop_front();
            if (cycle != due) begin
                failures++;
                $display("[TB] FAIL wr_ch%0d: ready at cycle %0d, expected cycle %0d", c, cycle, due);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (rd_ready[c] === 1'b1) mon_read(c);
            if (wr_ready[c] === 1'b1) mon_write(c);
        end
    end

    task automatic do_init(input logic [ADDR_BITS-1:0] addr, input logic [DATA_BITS-1:0] data);
        @(posedge clk); #1;
        init_we   = 1'b1;
        init_addr = addr;
        init_data = data;
        model[addr] = data;
        @(posedge clk); #1;
        init_we = 1'b0;
    endtask

    // Single-channel request, valid held 'extra' cycles past the ready edge.
    task automatic issue_op(input int ch, input bit is_write, input logic [ADDR_BITS-1:0] addr,
                            input logic [DATA_BITS-1:0] data, input int extra);
        @(posedge clk); #1;
        if (is_write) begin
            wr_valid[ch] = 1'b1;
            wr_addr[ch*ADDR_BITS +: ADDR_BITS] = addr;
            wr_data[ch*DATA_BITS +: DATA_BITS] = data;
            push_write(ch, cycle + 1 + WL);
            model[addr] = data;
            repeat (1 + WL + extra) @(posedge clk);
            #1;
            wr_valid[ch] = 1'b0;
        end else begin
            rd_valid[ch] = 1'b1;
            rd_addr[ch*ADDR_BITS +: ADDR_BITS] = addr;
            push_read(ch, addr);
            repeat (1 + RL + extra) @(posedge clk);
            #1;
            rd_valid[ch] = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check_val({tag, "_rd_ready"}, 32'(rd_ready), 32'd0);
        check_val({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
        check_val({tag, "_rd_data"}, rd_data, 32'd0);
    endtask

    initial begin
        int kind;
        logic [ADDR_BITS-1:0] a;

        // Preload a working window while held in reset.
        for (int i = 16; i < 24; i++) begin
            do_init(ADDR_BITS'(i), DATA_BITS'($urandom));
        end

        // Reset with valids high: outputs stay quiet, first ready after release.
        @(posedge clk); #1;
        rd_valid = 2'b11;
        rd_addr  = {8'h11, 8'h10};
        repeat (3) check_reset_outputs("reset_hold");
        @(posedge clk); #1;
        reset = 1'b1;
        push_read(0, 8'h10);
        push_read(1, 8'h11);
        repeat (1 + RL) @(posedge clk);
        #1;
        rd_valid = '0;

        // Write then read back through channel 0.
        issue_op(0, 1'b1, 8'h12, 16'hBEEF, 0);
        issue_op(0, 0, 8'h12, 16'h0, 0);

        // Stale read valid held through DRAIN while a write waits behind it.
        @(posedge clk); #1;
        rd_valid[0] = 1'b1;
        rd_addr[7:0] = 8'h14;
        push_read(0, 8'h14);
        repeat (1 + RL) @(posedge clk);
        #1;
        wr_valid[0] = 1'b1;
        wr_addr[7:0] = 8'h15;
        wr_data[15:0] = 16'h3C3C;
        repeat (2) @(posedge clk);
        #1;
        rd_valid[0] = 1'b0;
        push_write(0, cycle + 2 + WL);
        model[8'h15] = 16'h3C3C;
        repeat (2 + WL) @(posedge clk);
        #1;
        wr_valid[0] = 1'b0;
        issue_op(0, 0, 8'h15, 16'h0, 0);

        // Same-edge writes to one address: apply in channel order, last one stands.
        @(posedge clk); #1;
        wr_valid = 2'b11;
        wr_addr  = {8'h40, 8'h40};
        wr_data  = {16'h2222, 16'h1111};
        push_write(0, cycle + 1 + WL);
        push_write(1, cycle + 1 + WL);
        model[8'h40] = 16'h1111;
        model[8'h40] = 16'h2222;
        repeat (1 + WL) @(posedge clk);
        #1;
        wr_valid = '0;
        issue_op(0, 0, 8'h40, 16'h0, 0);
        issue_op(1, 0, 8'h40, 16'h0, 0);

        // Read on ch0 completes on the same edge as a ch1 write to the same word.
        do_init(8'h05, 16'h00AA);
        @(posedge clk); #1;
        rd_valid[0] = 1'b1;
        rd_addr[7:0] = 8'h05;
        push_read(0, 8'h05);
        @(posedge clk); #1;
        wr_valid[1] = 1'b1;
        wr_addr[15:8] = 8'h05;
        wr_data[31:16] = 16'h5555;
        push_write(1, cycle + 1 + WL);
        model[8'h05] = 16'h5555;
        repeat (2) @(posedge clk);
        #1;
        rd_valid[0] = 1'b0;
        wr_valid[1] = 1'b0;
        issue_op(0, 0, 8'h05, 16'h0, 0);
        issue_op(1, 0, 8'h05, 16'h0, 0);

        // Reset lands mid-request: neither the read nor the write may complete.
        @(posedge clk); #1;
        rd_valid[0] = 1'b1;
        rd_addr[7:0] = 8'h12;
        wr_valid[1] = 1'b1;
        wr_addr[15:8] = 8'h13;
        wr_data[31:16] = 16'hDEAD;
        @(posedge clk); #2;
        reset    = 1'b0;
        rd_valid = '0;
        wr_valid = '0;
        repeat (2) check_reset_outputs("reset_abort");
        @(posedge clk); #1;
        reset = 1'b1;
        issue_op(1, 0, 8'h13, 16'h0, 0);
        issue_op(0, 0, 8'h12, 16'h0, 0);

        // Random single-channel traffic against the model.
        repeat (60) begin
            kind = int'($urandom_range(0, 4));
            a    = ADDR_BITS'(16 + $urandom_range(0, 7));
            if (kind <= 1) begin
                issue_op(int'($urandom_range(0, 1)), 1'b0, a, 16'h0, int'($urandom_range(0, 2)));
            end else if (kind <= 3) begin
                issue_op(int'($urandom_range(0, 1)), 1'b1, a, DATA_BITS'($urandom), int'($urandom_range(0, 2)));
            end else begin
                do_init(a, DATA_BITS'($urandom));
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (6) @(posedge clk);
        #1;
        check_val("rd_q0_drained", 32'(rd_q0.size()), 32'd0);
        check_val("rd_q1_drained", 32'(rd_q1.size()), 32'd0);
        check_val("wr_q0_drained", 32'(wr_q0.size()), 32'd0);
        check_val("wr_q1_drained", 32'(wr_q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
